// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// The state encodings are plain constants so older code that stores the state as logic [1:0] still matches.
package pwm_capture_pkg;

   localparam int SyncStages = 2;
   localparam int MeasW = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   localparam logic [1:0] ST_STUCK = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      HIGH  = ST_HIGH,
      LOW   = ST_LOW,
      STUCK = ST_STUCK
   } cap_state_e;

   typedef struct packed {
      logic [MeasW-1:0] period;
      logic [MeasW-1:0] high;
      logic             overflow;
   } cap_meas_t;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for signals crossing into the clk_i domain.
module prim_flop_2sync #(
   parameter int               Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] stage1_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage1_q <= ResetValue;
         q_o      <= ResetValue;
      end else begin
         stage1_q <= d_i;
         q_o      <= stage1_q;
      end
   end

endmodule

// File: rtl/pwm_capture_filter.sv
// Stable-count glitch filter: the output follows the input only after FiltCycles consecutive
// samples that differ from the current output.
module pwm_capture_filter #(
   parameter int FiltCycles = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   localparam int CW = $clog2(FiltCycles + 1);

   logic [CW-1:0] stable_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o      <= 1'b0;
         stable_q <= '0;
      end else if (d_i == q_o) begin
         stable_q <= '0;
      end else if (stable_q == CW'(FiltCycles - 1)) begin
         q_o      <= d_i;
         stable_q <= '0;
      end else begin
         stable_q <= stable_q + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM line and flags a stuck line.
// Define PWM_CAPTURE_FILTER_EN to insert a glitch filter after the synchroniser.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CntW       = 16,
   parameter int FiltCycles = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            enable_i,
   input  logic [CntW-1:0] timeout_i,
   input  logic            pwm_i,
   output logic            meas_valid_o,
   output logic [CntW-1:0] period_o,
   output logic [CntW-1:0] high_o,
   output logic            overflow_o,
   output logic            stuck_o,
   output logic            stuck_level_o
);

   localparam logic [CntW-1:0] CntMax = '1;

   logic            sync_lvl;
   logic            level;
   logic            level_prev_q;
   logic            rise;
   logic            fall;
   logic            timeout_hit;
   logic            measuring;
   logic [1:0]      state_q;
   logic [1:0]      state_d;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] hi_q;
   logic            ovf_q;

   prim_flop_2sync #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pwm_i),
      .q_o    (sync_lvl)
   );

`ifdef PWM_CAPTURE_FILTER_EN
   pwm_capture_filter #(
      .FiltCycles (FiltCycles)
   ) u_filter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (sync_lvl),
      .q_o    (level)
   );
`else
   assign level = sync_lvl;
`endif

   // The previous sample keeps tracking while disabled so re-enabling never fakes an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level;
      end
   end

   assign rise        = level & ~level_prev_q;
   assign fall        = ~level & level_prev_q;
   assign measuring   = (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign timeout_hit = measuring && (timeout_i != '0) && (cnt_q >= timeout_i) && !rise && !fall;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (rise) state_d = ST_HIGH;
         ST_HIGH:  if (fall) state_d = ST_LOW;  else if (timeout_hit) state_d = ST_STUCK;
         ST_LOW:   if (rise) state_d = ST_HIGH; else if (timeout_hit) state_d = ST_STUCK;
         ST_STUCK: if (rise) state_d = ST_HIGH; else if (fall) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (!enable_i) begin
         state_d = ST_IDLE;
      end
   end

   // A measurement is only published on a rise seen from LOW, i.e. after a full rise-fall-rise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         hi_q          <= '0;
         ovf_q         <= 1'b0;
         meas_valid_o  <= 1'b0;
         period_o      <= '0;
         high_o        <= '0;
         overflow_o    <= 1'b0;
         stuck_o       <= 1'b0;
         stuck_level_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         meas_valid_o  <= 1'b0;
         stuck_o       <= (state_d == ST_STUCK);
         stuck_level_o <= (state_d == ST_STUCK) & level;
         if (!enable_i) begin
            cnt_q <= '0;
         end else if (rise) begin
            cnt_q <= CntW'(1);
            ovf_q <= 1'b0;
            if (state_q == ST_LOW) begin
               period_o     <= cnt_q;
               high_o       <= hi_q;
               overflow_o   <= ovf_q;
               meas_valid_o <= 1'b1;
            end
         end else if (measuring) begin
            if (cnt_q == CntMax) begin
               ovf_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == ST_HIGH) && fall) begin
               hi_q <= cnt_q;
            end
         end
      end
   end

   a_outputs_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({meas_valid_o, period_o, high_o, overflow_o, stuck_o, stuck_level_o}));

   a_single_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      meas_valid_o |=> !meas_valid_o);

   a_filt_cfg: assert property (@(posedge clk_i) FiltCycles >= 1);

endmodule
